// File: rtl/tach_pkg.sv
// rtl/tach_pkg.sv - shared constants, state enums and width helpers for the fan tachometer
package tach_pkg;

    localparam longint unsigned SEC_PER_MIN = 64'd60;

    typedef enum logic [0:0] {
        CH_ARMING,
        CH_MEASURING
    } ch_state_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

    function automatic int calc_num_w(input longint unsigned clk_freq);
        return $clog2(SEC_PER_MIN * clk_freq + 64'd1);
    endfunction

    function automatic int calc_cnt_w(input longint unsigned timeout_cyc);
        return $clog2(timeout_cyc + 64'd1);
    endfunction

endpackage

// File: rtl/tach_seq_div.sv
// rtl/tach_seq_div.sv - restoring divider, one quotient bit per cycle, with a tag carried alongside
module tach_seq_div
    import tach_pkg::*;
#(
    parameter int NUM_W = 32,
    parameter int DEN_W = 16,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot,
    output logic [TAG_W-1:0] tag_out
);

    localparam int IT_W = $clog2(NUM_W);

    div_state_e       state;
    logic [DEN_W-1:0] den_q;
    logic [DEN_W-1:0] rem;
    logic [IT_W-1:0]  iter;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W:0]   rem_sub;
    logic             take;

    // quot starts as the numerator and is shifted out MSB-first while quotient bits shift in
    always_comb begin
        rem_sh  = {rem, quot[NUM_W-1]};
        rem_sub = rem_sh - {1'b0, den_q};
        take    = (rem_sh >= {1'b0, den_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            den_q   <= '0;
            rem     <= '0;
            iter    <= '0;
            quot    <= '0;
            tag_out <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        den_q   <= den;
                        rem     <= '0;
                        iter    <= '0;
                        quot    <= num;
                        tag_out <= tag_in;
                        state   <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    rem  <= take ? rem_sub[DEN_W-1:0] : rem_sh[DEN_W-1:0];
                    quot <= {quot[NUM_W-2:0], take};
                    iter <= iter + 1'b1;
                    if (iter == IT_W'(NUM_W - 1)) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = (state != DIV_IDLE);
    assign done = (state == DIV_DONE);

endmodule

// File: rtl/tach_multi_acq.sv
// rtl/tach_multi_acq.sv - multi-channel FG period to RPM with stall detect; FG_GLITCH_FILTER_EN adds an input glitch filter
module tach_multi_acq
    import tach_pkg::*;
#(
    parameter int CH_NUM      = 2,
    parameter int CLK_FREQ    = 50000000,
    parameter int PPR         = 2,
    parameter int TIMEOUT_CYC = CLK_FREQ,
`ifdef FG_GLITCH_FILTER_EN
    parameter int FILT_CYC    = 4,
`endif
    parameter int RPM_W       = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [CH_NUM-1:0]         fg_signal,
    output logic [CH_NUM*RPM_W-1:0]   rpm_flat,
    output logic [CH_NUM-1:0]         rpm_valid,
    output logic [CH_NUM-1:0]         stall
);

    localparam int NUM_W = calc_num_w(64'(CLK_FREQ));
    localparam int CNT_W = calc_cnt_w(64'(TIMEOUT_CYC));
    localparam int DEN_W = CNT_W + 2;
    localparam int TAG_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int QW    = (NUM_W > RPM_W) ? NUM_W : RPM_W;
    localparam logic [NUM_W-1:0] NUMER = NUM_W'(SEC_PER_MIN * 64'(CLK_FREQ));

    logic [CH_NUM-1:0] sync1, sync2, lvl, lvl_d, fg_edge, post, tmo, pending;
    ch_state_e         ch_state [CH_NUM];
    logic [CNT_W-1:0]  cnt      [CH_NUM];
    logic [CNT_W-1:0]  p_lat    [CH_NUM];
    logic [RPM_W-1:0]  rpm_q    [CH_NUM];
    logic [TAG_W-1:0]  ptr, grant_ch, div_tag;
    logic              grant_vld, div_busy, div_done, discard, tmo_tag;
    logic [NUM_W-1:0]  div_quot;
    logic [QW-1:0]     q_ext;
    logic [RPM_W-1:0]  rpm_sat;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_d <= '0;
        end else begin
            sync1 <= fg_signal;
            sync2 <= sync1;
            lvl_d <= lvl;
        end
    end

`ifdef FG_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);
    logic [FW-1:0]     fcnt [CH_NUM];
    logic [CH_NUM-1:0] filt;

    // level follows the input only after FILT_CYC consecutive cycles at the new value
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            filt <= '0;
            for (int i = 0; i < CH_NUM; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_CYC - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end
    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    assign fg_edge = lvl & ~lvl_d;

    // an edge on the timeout cycle suppresses the stall
    always_comb begin
        post = '0;
        tmo  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            post[i] = fg_edge[i] && (ch_state[i] == CH_MEASURING);
            tmo[i]  = !fg_edge[i] && (ch_state[i] == CH_MEASURING)
                      && (cnt[i] == CNT_W'(TIMEOUT_CYC));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!grant_vld && pending[(int'(ptr) + k) % CH_NUM]) begin
                grant_vld = 1'b1;
                grant_ch  = TAG_W'((int'(ptr) + k) % CH_NUM);
            end
        end
        if (div_busy) grant_vld = 1'b0;
    end

    always_comb begin
        tmo_tag = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (tmo[i] && div_tag == TAG_W'(i)) tmo_tag = 1'b1;
        end
    end

    tach_seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .TAG_W (TAG_W)
    ) u_div (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .start   (grant_vld),
        .num     (NUMER),
        .den     (DEN_W'(p_lat[grant_ch]) * DEN_W'(PPR)),
        .tag_in  (grant_ch),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (div_quot),
        .tag_out (div_tag)
    );

    assign q_ext   = QW'(div_quot);
    assign rpm_sat = (q_ext > QW'({RPM_W{1'b1}})) ? {RPM_W{1'b1}} : q_ext[RPM_W-1:0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending   <= '0;
            stall     <= '0;
            rpm_valid <= '0;
            ptr       <= '0;
            discard   <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                ch_state[i] <= CH_ARMING;
                cnt[i]      <= '0;
                p_lat[i]    <= '0;
                rpm_q[i]    <= '0;
            end
        end else begin
            rpm_valid <= '0;
            if (grant_vld) begin
                ptr <= (grant_ch == TAG_W'(CH_NUM - 1)) ? '0 : grant_ch + 1'b1;
            end
            if (grant_vld)                discard <= 1'b0;
            else if (div_busy && tmo_tag) discard <= 1'b1;

            for (int i = 0; i < CH_NUM; i++) begin
                if (grant_vld && grant_ch == TAG_W'(i)) pending[i] <= 1'b0;
                // a stall in the same cycle as completion wins over the stale result
                if (div_done && div_tag == TAG_W'(i) && !discard && !tmo[i]) begin
                    rpm_q[i]     <= rpm_sat;
                    rpm_valid[i] <= 1'b1;
                end
                if (ch_state[i] == CH_ARMING) begin
                    if (fg_edge[i]) begin
                        ch_state[i] <= CH_MEASURING;
                        cnt[i]      <= CNT_W'(1);
                    end
                end else if (fg_edge[i]) begin
                    cnt[i]     <= CNT_W'(1);
                    p_lat[i]   <= cnt[i];
                    pending[i] <= 1'b1;
                    stall[i]   <= 1'b0;
                end else if (tmo[i]) begin
                    ch_state[i]  <= CH_ARMING;
                    cnt[i]       <= '0;
                    stall[i]     <= 1'b1;
                    rpm_q[i]     <= '0;
                    rpm_valid[i] <= 1'b1;
                    pending[i]   <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_rpm
        assign rpm_flat[g*RPM_W +: RPM_W] = rpm_q[g];
    end

endmodule

// File: tb/tb_tach_multi_acq.sv
// tb/tb_tach_multi_acq.sv - scoreboard bench for tach_multi_acq (4 channels, 100 kHz clock, PPR 2)
module tb_tach_multi_acq;

    localparam int CH    = 4;
    localparam int RW    = 16;
    localparam int TMO   = 8000;
    localparam int NUM_W = 23;          // clog2(60 * 100000 + 1)
    localparam int LAT   = NUM_W + 2;   // grant to rpm_valid
    localparam int P2E   = 3;           // pin drive to registered edge / grant cycle

    typedef struct {
        int ch;
        int rpm;
        int at;
        bit stl;
    } exp_t;

    logic                sys_clk   = 1'b0;
    logic                sys_rst   = 1'b1;
    logic [CH-1:0]       fg_signal = '0;
    logic [CH*RW-1:0]    rpm_flat;
    logic [CH-1:0]       rpm_valid;
    logic [CH-1:0]       stall;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   mon_idx;
    exp_t sbq[$];
    int   rpm_t[CH] = '{1500, 1000, 750, 500};

    tach_multi_acq #(
        .CH_NUM      (CH),
        .CLK_FREQ    (100000),
        .PPR         (2),
        .TIMEOUT_CYC (TMO),
        .RPM_W       (RW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .fg_signal (fg_signal),
        .rpm_flat  (rpm_flat),
        .rpm_valid (rpm_valid),
        .stall     (stall)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic int rpm_of(input int i);
        return int'(rpm_flat[i*RW +: RW]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse(input int c, input logic [CH-1:0] m);
        goto(c);
        fg_signal = fg_signal | m;
        goto(c + 4);
        fg_signal = fg_signal & ~m;
    endtask

    task automatic push(input int ch, input int rpm, input int at, input bit stl);
        exp_t e;
        e.ch = ch; e.rpm = rpm; e.at = at; e.stl = stl;
        sbq.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rpm_valid[i]) begin
                mon_idx = -1;
                foreach (sbq[j]) if (mon_idx < 0 && sbq[j].ch == i) mon_idx = j;
                if (mon_idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid ch%0d actual rpm=%0d at cycle %0d required no pulse",
                             i, rpm_of(i), cyc);
                end else begin
                    check($sformatf("rpm_ch%0d", i), rpm_of(i), sbq[mon_idx].rpm);
                    check($sformatf("valid_cycle_ch%0d", i), cyc, sbq[mon_idx].at);
                    check($sformatf("stall_at_valid_ch%0d", i), stall[i], sbq[mon_idx].stl);
                    sbq.delete(mon_idx);
                end
            end
        end
    end

    initial begin
        goto(3);
        sys_rst = 1'b0;
        check("reset_rpm", rpm_flat, 0);
        check("reset_valid", rpm_valid, 0);
        check("reset_stall", stall, 0);

        // ch0: period 2000 -> 6e6 / 4000 = 1500; first edge only arms
        pulse(10, 4'b0001);
        push(0, 1500, 2010 + P2E + LAT, 0);
        pulse(2010, 4'b0001);

        // ch1: period 10 -> 300000, saturates
        pulse(2100, 4'b0010);
        push(1, 65535, 2110 + P2E + LAT, 0);
        push(1, 0, 2110 + P2E + TMO, 1);
        pulse(2110, 4'b0010);

        // ch0 third edge, then silence -> stall TMO cycles after it
        push(0, 1500, 4010 + P2E + LAT, 0);
        push(0, 0, 4010 + P2E + TMO, 1);
        pulse(4010, 4'b0001);

        goto(12050);
        check("stall_both", stall, 4'b0011);
        check("stall_rpm_ch0", rpm_of(0), 0);
        check("stall_rpm_ch1", rpm_of(1), 0);

        // restart ch0: arming edge keeps stall, second edge clears it
        pulse(12100, 4'b0001);
        goto(14050);
        check("stall_after_arm", stall, 4'b0011);
        push(0, 1500, 14100 + P2E + LAT, 0);
        pulse(14100, 4'b0001);
        goto(14110);
        check("stall_after_post", stall, 4'b0010);

        // reset in the middle of the ch0 division: result must never appear
        pulse(16100, 4'b0001);
        goto(16110);
        sys_rst = 1'b1;
        goto(16111);
        sys_rst = 1'b0;
        check("midrst_rpm", rpm_flat, 0);
        check("midrst_stall", stall, 0);
        check("midrst_valid", rpm_valid, 0);

        // four channels post together; served ch0..ch3, LAT apart
        pulse(16200, 4'b1000);
        pulse(18200, 4'b0100);
        pulse(19200, 4'b0010);
        pulse(20200, 4'b0001);
        for (int j = 0; j < CH; j++) push(j, rpm_t[j], 22200 + P2E + LAT * (j + 1), 0);
        pulse(22200, 4'b1111);

        goto(22400);
        check("final_rpm_flat", rpm_flat, {16'd500, 16'd750, 16'd1000, 16'd1500});
        check("final_stall", stall, 0);
        check("scoreboard_left", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
